// File: rtl/vdp_super_arb_pkg.sv
// Shared types and helpers for the super-res VRAM arbiter: FSM states,
// read-return tags and byte-lane helpers.
package vdp_super_arb_pkg;

    localparam int TAG_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISP_REQ = 2'd1,
        CPU_REQ  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic       is_cpu;
        logic [1:0] byte_sel;
    } rd_tag_t;

    function automatic logic [3:0] byte_onehot(input logic [1:0] sel);
        return 4'(4'b0001 << sel);
    endfunction

    function automatic logic [7:0] select_byte(input logic [31:0] data, input logic [1:0] sel);
        return data[8*sel +: 8];
    endfunction

endpackage

// File: rtl/vdp_super_rd_tag_fifo.sv
// In-order tag FIFO pairing outstanding VRAM reads with their requester.
// Show-ahead head, registered occupancy, push and pop allowed together even when full.
module vdp_super_rd_tag_fifo
    import vdp_super_arb_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEFAULT
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  rd_tag_t push_tag,
    input  logic    pop,
    output rd_tag_t head_tag,
    output logic    full,
    output logic    empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rd_tag_t       tag_mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head_tag = tag_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) tag_mem[wr_ptr_reg] <= push_tag;
    end

endmodule

// File: rtl/vdp_super_vram_arbiter.sv
// Shares the 32-bit VRAM port between the super-res display fetch and CPU
// byte accesses; read returns are routed back through an in-order tag FIFO.
module vdp_super_vram_arbiter
    import vdp_super_arb_pkg::*;
#(
    parameter int TAG_DEPTH = TAG_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vdp_super,
    input  logic        super_res_drawing,
    input  logic [17:0] super_res_vram_addr,
    output logic [31:0] vrm_32,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [17:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rd_valid,
    output logic [7:0]  cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rdata,
    output logic        rd_underflow
);

    arb_state_e  state_reg, state_next;
    logic        start_disp, start_cpu;

    logic        draw_prev_reg;
    logic        last_valid_reg;
    logic [15:0] last_word_reg;
    logic [1:0]  byte_sel_reg;
    logic        mem_we_reg;
    logic [15:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [3:0]  mem_be_reg;
    logic        cpu_ack_reg;
    logic        cpu_rd_valid_reg;
    logic [7:0]  cpu_rdata_reg;
    logic [31:0] vrm_32_reg;
    logic        rd_underflow_reg;

    logic        draw_act, draw_rise, disp_demand, cpu_eligible;
    logic [15:0] disp_word;
    logic [31:0] wdata_rep;
    logic        hs_done;
    logic        tag_push, tag_full, tag_empty;
    rd_tag_t     push_tag, head_tag;
    logic        unused_addr_lsbs;

    assign draw_act  = vdp_super && super_res_drawing;
    assign draw_rise = draw_act && !draw_prev_reg;
    assign disp_word = super_res_vram_addr[17:2];
    assign unused_addr_lsbs = ^super_res_vram_addr[1:0];

    assign disp_demand = draw_act && (draw_rise || !last_valid_reg || (disp_word != last_word_reg));
    // The ack cycle is masked so a CPU still holding req sees no second access.
    assign cpu_eligible = cpu_req && !draw_act && !cpu_ack_reg && (cpu_we || !tag_full);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wdata_rep
            assign wdata_rep[gi*8 +: 8] = cpu_wdata;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        start_disp = 1'b0;
        start_cpu  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (disp_demand && !tag_full) begin
                    start_disp = 1'b1;
                    state_next = DISP_REQ;
                end else if (cpu_eligible) begin
                    start_cpu  = 1'b1;
                    state_next = CPU_REQ;
                end
            end
            DISP_REQ, CPU_REQ: begin
                if (mem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    assign hs_done  = (state_reg != IDLE) && mem_ack;
    assign tag_push = hs_done && !mem_we_reg;

    always_comb begin
        push_tag.is_cpu   = (state_reg == CPU_REQ);
        push_tag.byte_sel = byte_sel_reg;
    end

    vdp_super_rd_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tag_push),
        .push_tag (push_tag),
        .pop      (mem_rd_valid),
        .head_tag (head_tag),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            draw_prev_reg    <= 1'b0;
            last_valid_reg   <= 1'b0;
            last_word_reg    <= '0;
            byte_sel_reg     <= '0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= '0;
            mem_be_reg       <= '0;
            cpu_ack_reg      <= 1'b0;
            cpu_rd_valid_reg <= 1'b0;
            cpu_rdata_reg    <= '0;
            vrm_32_reg       <= '0;
            rd_underflow_reg <= 1'b0;
        end else begin
            draw_prev_reg <= draw_act;

            // A drawing edge forgets the last word unless this very cycle fetches it.
            if (start_disp) begin
                mem_addr_reg   <= disp_word;
                mem_we_reg     <= 1'b0;
                mem_be_reg     <= 4'hF;
                byte_sel_reg   <= 2'd0;
                last_word_reg  <= disp_word;
                last_valid_reg <= 1'b1;
            end else if (draw_rise) begin
                last_valid_reg <= 1'b0;
            end

            if (start_cpu) begin
                mem_addr_reg <= cpu_addr[17:2];
                mem_we_reg   <= cpu_we;
                byte_sel_reg <= cpu_addr[1:0];
                if (cpu_we) begin
                    mem_be_reg    <= byte_onehot(cpu_addr[1:0]);
                    mem_wdata_reg <= wdata_rep;
                end else begin
                    mem_be_reg    <= 4'hF;
                end
            end

            cpu_ack_reg      <= hs_done && (state_reg == CPU_REQ);
            cpu_rd_valid_reg <= mem_rd_valid && !tag_empty && head_tag.is_cpu;

            if (mem_rd_valid && !tag_empty) begin
                if (head_tag.is_cpu) cpu_rdata_reg <= select_byte(mem_rdata, head_tag.byte_sel);
                else                 vrm_32_reg    <= mem_rdata;
            end

            if (mem_rd_valid && tag_empty) rd_underflow_reg <= 1'b1;
        end
    end

    assign mem_req      = (state_reg != IDLE);
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign mem_be       = mem_be_reg;
    assign cpu_ack      = cpu_ack_reg;
    assign cpu_rd_valid = cpu_rd_valid_reg;
    assign cpu_rdata    = cpu_rdata_reg;
    assign vrm_32       = vrm_32_reg;
    assign rd_underflow = rd_underflow_reg;

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// Bench for the super-res VRAM arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a queue model.
module tb_vdp_super_vram_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        vdp_super;
    logic        super_res_drawing;
    logic [17:0] super_res_vram_addr;
    logic [31:0] vrm_32;
    logic        cpu_req;
    logic        cpu_we;
    logic [17:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic        cpu_rd_valid;
    logic [7:0]  cpu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        mem_rd_valid;
    logic [31:0] mem_rdata;
    logic        rd_underflow;

    vdp_super_vram_arbiter #(.TAG_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .vdp_super           (vdp_super),
        .super_res_drawing   (super_res_drawing),
        .super_res_vram_addr (super_res_vram_addr),
        .vrm_32              (vrm_32),
        .cpu_req             (cpu_req),
        .cpu_we              (cpu_we),
        .cpu_addr            (cpu_addr),
        .cpu_wdata           (cpu_wdata),
        .cpu_ack             (cpu_ack),
        .cpu_rd_valid        (cpu_rd_valid),
        .cpu_rdata           (cpu_rdata),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_be              (mem_be),
        .mem_ack             (mem_ack),
        .mem_rd_valid        (mem_rd_valid),
        .mem_rdata           (mem_rdata),
        .rd_underflow        (rd_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       is_cpu;
        bit [1:0] sel;
    } mtag_t;

    mtag_t     m_q[$];
    bit        started = 1'b0;
    bit        m_pend, m_pend_cpu, m_we;
    bit [15:0] m_addr;
    bit [3:0]  m_be;
    bit [31:0] m_wdata;
    bit [1:0]  m_sel;
    bit        m_lv, m_prev;
    bit [15:0] m_lw;
    bit [31:0] m_vrm;
    bit [7:0]  m_crd;
    bit        m_crv, m_cack, m_uf;

    always @(posedge clk) begin : model
        bit        draw, rise, dem;
        int        occ;
        bit [15:0] w;
        bit [31:0] sh;
        mtag_t     t;
        if (reset) begin
            m_q.delete();
            started = 1'b1;
            m_pend = 0; m_pend_cpu = 0; m_we = 0; m_addr = 0; m_be = 0; m_wdata = 0;
            m_sel = 0; m_lv = 0; m_prev = 0; m_lw = 0; m_vrm = 0; m_crd = 0;
            m_crv = 0; m_cack = 0; m_uf = 0;
        end else begin
            draw = vdp_super && super_res_drawing;
            rise = draw && !m_prev;
            w    = super_res_vram_addr[17:2];
            occ  = m_q.size();
            m_crv  = 0;
            m_cack = 0;
            if (mem_rd_valid) begin
                if (occ == 0) m_uf = 1;
                else begin
                    t = m_q.pop_front();
                    if (t.is_cpu) begin
                        sh    = mem_rdata >> (8 * t.sel);
                        m_crd = sh[7:0];
                        m_crv = 1;
                    end else begin
                        m_vrm = mem_rdata;
                    end
                end
            end
            if (rise) m_lv = 0;
            if (m_pend) begin
                if (mem_ack) begin
                    if (!m_we) begin
                        t.is_cpu = m_pend_cpu;
                        t.sel    = m_sel;
                        m_q.push_back(t);
                    end
                    m_cack = m_pend_cpu;
                    m_pend = 0;
                end
            end else begin
                dem = draw && (!m_lv || w != m_lw);
                if (dem && occ < DEPTH) begin
                    m_pend = 1; m_pend_cpu = 0; m_we = 0; m_addr = w; m_be = 4'hF; m_sel = 0;
                    m_lv = 1; m_lw = w;
                end else if (cpu_req && !draw && (cpu_we || occ < DEPTH)) begin
                    m_pend = 1; m_pend_cpu = 1; m_we = cpu_we; m_addr = cpu_addr[17:2];
                    m_sel = cpu_addr[1:0];
                    if (cpu_we) begin
                        m_be    = 4'(1 << cpu_addr[1:0]);
                        m_wdata = {4{cpu_wdata}};
                    end else begin
                        m_be = 4'hF;
                    end
                end
            end
            m_prev = draw;
        end
    end

    always @(negedge clk) begin : compare
        if (started) begin
            chk("mem_req", 32'(mem_req), 32'(m_pend));
            chk("cpu_ack", 32'(cpu_ack), 32'(m_cack));
            chk("cpu_rd_valid", 32'(cpu_rd_valid), 32'(m_crv));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(m_crd));
            chk("vrm_32", vrm_32, m_vrm);
            chk("rd_underflow", 32'(rd_underflow), 32'(m_uf));
            if (mem_req) begin
                chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                chk("mem_we", 32'(mem_we), 32'(m_we));
                chk("mem_be", 32'(mem_be), 32'(m_be));
                if (mem_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
        end
    end

    // ---------------- stimulus / memory responder ----------------
    bit          auto_ack = 0, ack_rand = 0, auto_ret = 0;
    int          outstanding = 0;
    int          n_issued = 0;
    logic [15:0] issued_q[$];

    task automatic step();
        if (cpu_req && cpu_ack) cpu_req = 1'b0;
        mem_ack = auto_ack && mem_req && (!ack_rand || ($urandom_range(0, 2) != 0));
        if (auto_ret) begin
            mem_rd_valid = (outstanding > 0) && ($urandom_range(0, 3) == 0);
            mem_rdata    = $urandom;
        end
        if (mem_req && mem_ack) begin
            n_issued++;
            issued_q.push_back(mem_addr);
            if (!mem_we) outstanding++;
        end
        if (mem_rd_valid && outstanding > 0) outstanding--;
        @(posedge clk);
        #1;
    endtask

    task automatic ret(input logic [31:0] data);
        mem_rd_valid = 1'b1;
        mem_rdata    = data;
        step();
        mem_rd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        auto_ret = 1;
        while ((outstanding > 0 || mem_req) && n < 300) begin
            step();
            n++;
        end
        auto_ret = 0;
        mem_rd_valid = 1'b0;
        chk("drain_done", 32'(outstanding > 0 || mem_req), 32'd0);
    endtask

    initial begin : stim
        int  prev;
        bit  had_out;
        reset = 1; vdp_super = 0; super_res_drawing = 0; super_res_vram_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 0; mem_rd_valid = 0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_vrm_32", vrm_32, 32'd0);
        chk("rst_underflow", 32'(rd_underflow), 32'd0);
        reset = 0;
        auto_ack = 1;
        step();

        // first display fetch
        vdp_super = 1; super_res_drawing = 1; super_res_vram_addr = 18'h00010;
        step();
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0004);
        chk("t1_mem_be", 32'(mem_be), 32'hF);
        step();
        step();
        ret(32'hDEADBEEF);
        chk("t1_vrm_32", vrm_32, 32'hDEADBEEF);

        // address stepping within and across words
        super_res_drawing = 0;
        step();
        issued_q.delete();
        super_res_drawing = 1; super_res_vram_addr = 18'h00010; step();
        super_res_vram_addr = 18'h00011; step();
        super_res_vram_addr = 18'h00012; step();
        super_res_vram_addr = 18'h00014; step();
        repeat (3) step();
        chk("t2_reads", 32'(issued_q.size()), 32'd2);
        chk("t2_word0", 32'(issued_q[0]), 32'h0004);
        chk("t2_word1", 32'(issued_q[1]), 32'h0005);
        drain();

        // CPU byte write
        super_res_drawing = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 18'h00003; cpu_wdata = 8'hA5;
        step();
        chk("t3_mem_be", 32'(mem_be), 32'h8);
        chk("t3_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("t3_mem_we", 32'(mem_we), 32'd1);
        step();
        chk("t3_cpu_ack", 32'(cpu_ack), 32'd1);
        step();
        chk("t3_cpu_ack_once", 32'(cpu_ack), 32'd0);

        // tag FIFO fills, fifth read waits for a return
        super_res_drawing = 1; super_res_vram_addr = 18'h00400;
        prev = n_issued;
        for (int i = 0; i < 20; i++) begin
            if (n_issued > prev) begin
                prev = n_issued;
                if (n_issued - (prev - (n_issued - prev)) >= 0 && issued_q.size() > 0 &&
                    super_res_vram_addr < 18'h00410)
                    super_res_vram_addr = super_res_vram_addr + 18'd4;
            end
            step();
        end
        chk("t4_outstanding", 32'(outstanding), 32'd4);
        chk("t4_blocked", 32'(mem_req), 32'd0);
        ret(32'hA0000000);
        chk("t4_vrm0", vrm_32, 32'hA0000000);
        chk("t4_still_blocked", 32'(mem_req), 32'd0);
        step();
        chk("t4_fifth_req", 32'(mem_req), 32'd1);
        chk("t4_fifth_addr", 32'(mem_addr), 32'h0104);
        step();
        ret(32'hA1111111);
        chk("t4_vrm1", vrm_32, 32'hA1111111);
        ret(32'hA2222222);
        ret(32'hA3333333);
        ret(32'hA4444444);
        chk("t4_vrm4", vrm_32, 32'hA4444444);
        chk("t4_empty", 32'(outstanding), 32'd0);

        // CPU read interleaved with display read
        super_res_drawing = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 18'h00002;
        step(); step(); step();
        super_res_drawing = 1; super_res_vram_addr = 18'h00800;
        step(); step();
        ret(32'h11223344);
        chk("t5_cpu_rd_valid", 32'(cpu_rd_valid), 32'd1);
        chk("t5_cpu_rdata", 32'(cpu_rdata), 32'h22);
        ret(32'h55667788);
        chk("t5_vrm_32", vrm_32, 32'h55667788);
        chk("t5_cpu_rd_valid_off", 32'(cpu_rd_valid), 32'd0);

        // return with nothing outstanding
        super_res_drawing = 0;
        step();
        ret(32'hBAD0BAD0);
        chk("t6_underflow", 32'(rd_underflow), 32'd1);
        repeat (4) step();
        chk("t6_sticky", 32'(rd_underflow), 32'd1);
        reset = 1; step(); step(); reset = 0;
        chk("t6_cleared", 32'(rd_underflow), 32'd0);

        // randomized traffic
        auto_ack = 1; ack_rand = 1; auto_ret = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) super_res_drawing = ~super_res_drawing;
            if ($urandom_range(0, 63) == 0) vdp_super = ~vdp_super;
            if ($urandom_range(0, 2) == 0)
                super_res_vram_addr = super_res_vram_addr + 18'($urandom_range(0, 6));
            if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 18'($urandom); cpu_wdata = 8'($urandom);
            end
            step();
        end
        issued_q.delete();

        // reset while reads are outstanding
        auto_ret = 0; mem_rd_valid = 0;
        vdp_super = 1; super_res_drawing = 1;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) super_res_vram_addr = super_res_vram_addr + 18'd4;
            step();
        end
        had_out = (outstanding > 0);
        reset = 1; step(); step(); reset = 0;
        cpu_req = 0; super_res_drawing = 0;
        drain();
        if (had_out) chk("reset_then_underflow", 32'(rd_underflow), 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vdp_super_vram_arbiter.md
# vdp_super_vram_arbiter

Arbitrates the 32-bit VRAM port between the super-res display fetch path and CPU byte accesses. It sits directly upstream of the super-res pixel stage:
- It consumes that stage's fetch address and drawing window.
- It returns the fetched 32-bit word as `vrm_32`.
- Outside the drawing window it serves CPU reads and writes.

Memory reads complete out of band. They are matched to their requester through an in-order tag FIFO.

## Interface
Parameters:
- `TAG_DEPTH`, default 4: maximum outstanding reads, a power of two.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `vdp_super` in 1: super mode enable. When 0, the display side is idle and `drawing` is ignored.
- `super_res_drawing` in 1: display fetch window.
- `super_res_vram_addr` in 18: display byte address. The word address is `[17:2]`.
- `vrm_32` out 32: last display word returned.
- `cpu_req` in 1: CPU access request, level. Held until `cpu_ack`.
- `cpu_we` in 1: 1 = write.
- `cpu_addr` in 18: CPU byte address.
- `cpu_wdata` in 8: CPU write byte.
- `cpu_ack` out 1: one-cycle pulse when the memory accepts the CPU access.
- `cpu_rd_valid` out 1: one-cycle pulse; `cpu_rdata` is valid.
- `cpu_rdata` out 8: CPU read byte.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1.
- `mem_addr` out 16: word address.
- `mem_wdata` out 32.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: request accepted this cycle.
- `mem_rd_valid` in 1: read data returned. Returns are in order.
- `mem_rdata` in 32.
- `rd_underflow` out 1: sticky flag; a return arrived with no outstanding tag.

## Operation
- States: `IDLE`, `DISP_REQ`, `CPU_REQ`.
- Display demand:
  - Raised when `vdp_super && super_res_drawing` and `super_res_vram_addr[17:2] != last_disp_word`.
  - Also raised on the first cycle of `drawing` after its rising edge, regardless of address. The edge invalidates `last_disp_word`.
- Priority in `IDLE`: display demand first. A CPU request is eligible only when `drawing` is 0 (or `vdp_super` is 0).
- Read gating: reads of either client need the tag FIFO to be not full. Writes need no tag.
- `IDLE` → `DISP_REQ`:
  - Latch the word address into `mem_addr`; `mem_we`=0, `mem_be`=4'hF.
  - Record `last_disp_word`.
- `IDLE` → `CPU_REQ`:
  - `mem_addr` = `cpu_addr[17:2]`.
  - Write: `mem_wdata` = `cpu_wdata` replicated ×4; `mem_be` = one-hot of `cpu_addr[1:0]`.
  - Read: `mem_be`=4'hF.
- `DISP_REQ` / `CPU_REQ` on `mem_ack`:
  - Drop `mem_req` and return to `IDLE`.
  - For reads, push a tag `{is_cpu, byte_sel[1:0]}`.
  - In `CPU_REQ`, pulse `cpu_ack`.
- On `mem_rd_valid`, pop a tag:
  - Display tag: `vrm_32` ← `mem_rdata`.
  - CPU tag: `cpu_rdata` ← selected byte of `mem_rdata`; pulse `cpu_rd_valid`.
  - Empty FIFO: discard the data and set `rd_underflow`.
- Boundary conditions:
  - A started handshake is never retracted. If `drawing` rises during `CPU_REQ`, the CPU access completes first.
  - If the display address changes during `DISP_REQ`, the latched address is issued. The new address is requested after the ack.
  - Push and pop in the same cycle is legal at any occupancy, including full.
  - Reset mid-operation clears the FIFO and state. Returns arriving afterwards count as underflow.

## Timing
- Reset values:
  - All pulse outputs and `mem_req` = 0.
  - `vrm_32`, `cpu_rdata`, `mem_addr`, `mem_wdata` = 0; `mem_be` = 0.
  - `rd_underflow` = 0; state = `IDLE`; FIFO empty.
  - `last_disp_word` invalid.
- Demand seen in cycle N → `mem_req` high in cycle N+1. `mem_req` stays high until and including the `mem_ack` cycle.
- The cycle after `mem_ack` is `IDLE`. Minimum issue interval is 2 cycles.
- `cpu_ack` is asserted in the cycle after `mem_ack`.
- `mem_rd_valid` in cycle M:
  - `vrm_32` updates at the edge ending M, visible in M+1.
  - `cpu_rd_valid` and `cpu_rdata` are visible in M+1.
- FIFO full is evaluated on registered occupancy. A pop in the same cycle does not unblock issue until the next cycle.

## Structure
- Package `vdp_super_arb_pkg`:
  - State enum.
  - Tag struct `{is_cpu, byte_sel}`.
  - `TAG_DEPTH` default constant.
- Sub-module `vdp_super_rd_tag_fifo`:
  - Parameterised depth.
  - Synchronous push/pop with `full`/`empty`, a registered count, and simultaneous push/pop support.
- Top level holds the FSM, demand detection and return routing.

## Test plan
- Reset, then `drawing`=1 at address 18'h00010 → one read at `mem_addr`=16'h0004. Return 32'hDEADBEEF → `vrm_32`=32'hDEADBEEF one cycle after `mem_rd_valid`.
- Display address steps 0x10, 0x11, 0x12, 0x14 → exactly two reads: word 0x4, then word 0x5.
- `drawing`=0, CPU write of 8'hA5 at 18'h00003 → `mem_be`=4'b1000, `mem_wdata`=32'hA5A5A5A5. `cpu_ack` pulses once.
- Stall `mem_rd_valid` and issue 5 display reads → only 4 issued (FIFO full). The 5th is issued one cycle after the first return. Data is routed in order.
- Interleaved CPU read at 18'h00002 and display read, returns 32'h11223344 then 32'h55667788 → `cpu_rdata`=8'h22 and `vrm_32`=32'h55667788.
- Pulse `mem_rd_valid` with no outstanding reads → `rd_underflow` goes high and stays high until reset.
